// File: rtl/toy_bus_ddec_node_reg.sv
// toy_bus_ddec_node_reg
// Registered 1-to-N target-ID decoder node for the ToyBus request network.
// Each input beat goes to the one output channel whose route-table entry
// matches its tgt_id. One output register stage runs at full throughput.
// A beat that matches no entry is consumed and dropped. The drop is reported
// on err_* and counted in a saturating err_cnt.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_vld/in_rdy               input handshake
//   in_opcode/data/src/tgt_id   input payload
//   out_vld[N_OUT]/out_rdy      per-channel handshake (out_vld is one-hot or 0)
//   out_opcode/data/src/tgt_id  registered payload, shared by all channels
//   err_vld                     one-cycle pulse for a dropped beat
//   err_src_id/err_tgt_id       IDs of the last dropped beat
//   err_cnt/err_cnt_clr         saturating drop counter, synchronous clear
module toy_bus_ddec_node_reg #(
  parameter int N_OUT = 2,
  parameter int DATA_W = 32,
  parameter int ID_W = 4,
  parameter logic [N_OUT*ID_W-1:0] RTE_ID = {4'd6, 4'd1},
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_vld,
  output logic              in_rdy,
  input  logic              in_opcode,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ID_W-1:0]   in_src_id,
  input  logic [ID_W-1:0]   in_tgt_id,
  output logic [N_OUT-1:0]  out_vld,
  input  logic [N_OUT-1:0]  out_rdy,
  output logic              out_opcode,
  output logic [DATA_W-1:0] out_data,
  output logic [ID_W-1:0]   out_src_id,
  output logic [ID_W-1:0]   out_tgt_id,
  output logic              err_vld,
  output logic [ID_W-1:0]   err_src_id,
  output logic [ID_W-1:0]   err_tgt_id,
  output logic [CNT_W-1:0]  err_cnt,
  input  logic              err_cnt_clr
);

  logic             v_q;
  logic [N_OUT-1:0] sel_q;
  logic [N_OUT-1:0] sel;
  logic             miss;
  logic             found;
  logic             fire_out;
  logic             acc_hit;
  logic             acc_miss;

  // Priority encode: the first matching entry, scanning up from index 0, wins.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < N_OUT; i++) begin
      if (!found && (in_tgt_id == RTE_ID[i*ID_W +: ID_W])) begin
        sel[i] = 1'b1;
        found  = 1'b1;
      end
    end
    miss = ~found;
  end

  assign out_vld  = {N_OUT{v_q}} & sel_q;
  // The mask with sel_q via out_vld ignores ready bits of channels that are not selected.
  assign fire_out = |(out_vld & out_rdy);
  assign in_rdy   = ~v_q | fire_out;
  assign acc_hit  = in_vld & in_rdy & ~miss;
  assign acc_miss = in_vld & in_rdy & miss;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q        <= 1'b0;
      sel_q      <= '0;
      out_opcode <= 1'b0;
      out_data   <= '0;
      out_src_id <= '0;
      out_tgt_id <= '0;
      err_vld    <= 1'b0;
      err_src_id <= '0;
      err_tgt_id <= '0;
      err_cnt    <= '0;
    end else begin
      if (acc_hit) begin
        v_q        <= 1'b1;
        sel_q      <= sel;
        out_opcode <= in_opcode;
        out_data   <= in_data;
        out_src_id <= in_src_id;
        out_tgt_id <= in_tgt_id;
      end else if (fire_out) begin
        v_q <= 1'b0;
      end

      err_vld <= acc_miss;
      if (acc_miss) begin
        err_src_id <= in_src_id;
        err_tgt_id <= in_tgt_id;
      end

      // A clear wins over an increment in the same cycle.
      if (err_cnt_clr) begin
        err_cnt <= '0;
      end else if (acc_miss && (err_cnt != {CNT_W{1'b1}})) begin
        err_cnt <= err_cnt + CNT_W'(1);
      end
    end
  end

endmodule
